// File: rtl/alu_ft_issue_if.sv
// Op-in and result-out channels of the ALU_ft issue stage.
// master = op producer / result consumer, slave = issue stage.
interface alu_ft_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_ctrl;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        res_retried;

    modport master (
        output in_valid, in_a, in_b, in_ctrl,
        input  in_ready, res_valid, res_data, res_flags, res_retried
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ctrl,
        output in_ready, res_valid, res_data, res_flags, res_retried
    );
endinterface

// File: rtl/alu_ft_issue.sv
// Operand issue stage for the time-redundant ALU_ft: op FIFO, STAGE1-aligned issue and result capture.
// Define ALU_FT_ISSUE_STATS_EN to add saturating op_count/fault_count counters.
module alu_ft_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_ft_issue_if.slave    bus,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [31:0]      ft_result,
    input  logic [3:0]       ft_flags,
    input  logic             ft_fault,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] fault_count
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    // PH1/PH2 follow ALU_ft STAGE1/STAGE2; PHX is STAGE1 or STAGE3 depending on ft_fault.
    typedef enum logic [1:0] {
        PH1 = 2'd0,
        PH2 = 2'd1,
        PHX = 2'd2
    } phase_t;

    phase_t        phase_r;
    phase_t        phase_nxt_s;

    logic [31:0]   fifo_a_r    [DEPTH];
    logic [31:0]   fifo_b_r    [DEPTH];
    logic [2:0]    fifo_ctrl_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic [31:0]   hold_a_r;
    logic [31:0]   hold_b_r;
    logic [2:0]    hold_ctrl_r;
    logic          inflight_r;
    logic          retry_pend_r;

    logic          res_valid_r;
    logic [31:0]   res_data_r;
    logic [3:0]    res_flags_r;
    logic          res_retried_r;

    logic          slot_s;
    logic          cap_clean_s;
    logic          cap_retry_s;
    logic          retry_set_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == FULL_CNT);
    assign push_s  = bus.in_valid & ~full_s;
    assign pop_s   = slot_s & ~empty_s;

    // Phase tracker state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= PH1;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Phase next-state plus per-phase issue-slot and completion strobes.
    always_comb begin
        phase_nxt_s = PH1;
        slot_s      = 1'b0;
        cap_clean_s = 1'b0;
        cap_retry_s = 1'b0;
        retry_set_s = 1'b0;
        case (phase_r)
            PH1: begin
                phase_nxt_s = PH2;
                slot_s      = 1'b1;
                cap_retry_s = retry_pend_r;
            end
            PH2: begin
                phase_nxt_s = PHX;
            end
            PHX: begin
                if (ft_fault) begin
                    phase_nxt_s = PH1;
                    retry_set_s = inflight_r;
                end else begin
                    phase_nxt_s = PH2;
                    slot_s      = 1'b1;
                    cap_clean_s = inflight_r;
                end
            end
            default: begin
                phase_nxt_s = PH1;
            end
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_a_r[i]    <= 32'd0;
                fifo_b_r[i]    <= 32'd0;
                fifo_ctrl_r[i] <= 3'd0;
            end
        end else if (push_s) begin
            fifo_a_r[wr_ptr_r]    <= bus.in_a;
            fifo_b_r[wr_ptr_r]    <= bus.in_b;
            fifo_ctrl_r[wr_ptr_r] <= bus.in_ctrl;
        end
    end

    // FIFO pointers and occupancy; a push while full never reaches here because in_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Operand hold registers keep the issued op stable through STAGE2 and STAGE3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_a_r    <= 32'd0;
            hold_b_r    <= 32'd0;
            hold_ctrl_r <= 3'd0;
        end else if (pop_s) begin
            hold_a_r    <= fifo_a_r[rd_ptr_r];
            hold_b_r    <= fifo_b_r[rd_ptr_r];
            hold_ctrl_r <= fifo_ctrl_r[rd_ptr_r];
        end
    end

    // In-flight and pending-retry tracking; every slot either issues or declares a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r   <= 1'b0;
            retry_pend_r <= 1'b0;
        end else begin
            if (slot_s) begin
                inflight_r <= ~empty_s;
            end
            if (retry_set_s) begin
                retry_pend_r <= 1'b1;
            end else if (cap_retry_s) begin
                retry_pend_r <= 1'b0;
            end
        end
    end

    // ALU_ft operand drive: FIFO head in an issuing slot, otherwise the held op.
    always_comb begin
        if (pop_s) begin
            alu_a    = fifo_a_r[rd_ptr_r];
            alu_b    = fifo_b_r[rd_ptr_r];
            alu_ctrl = fifo_ctrl_r[rd_ptr_r];
        end else begin
            alu_a    = hold_a_r;
            alu_b    = hold_b_r;
            alu_ctrl = hold_ctrl_r;
        end
    end

    // Result capture; data/flags/retried hold until the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r   <= 1'b0;
            res_data_r    <= 32'd0;
            res_flags_r   <= 4'd0;
            res_retried_r <= 1'b0;
        end else if (cap_clean_s) begin
            res_valid_r   <= 1'b1;
            res_data_r    <= ft_result;
            res_flags_r   <= ft_flags;
            res_retried_r <= 1'b0;
        end else if (cap_retry_s) begin
            res_valid_r   <= 1'b1;
            res_data_r    <= ft_result;
            res_flags_r   <= ft_flags;
            res_retried_r <= 1'b1;
        end else begin
            res_valid_r   <= 1'b0;
        end
    end

    assign bus.in_ready    = ~full_s;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_data    = res_data_r;
    assign bus.res_flags   = res_flags_r;
    assign bus.res_retried = res_retried_r;
    assign busy            = inflight_r | retry_pend_r | ~empty_s;

`ifdef ALU_FT_ISSUE_STATS_EN
    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] op_count_r;
    logic [CNT_W-1:0] fault_count_r;

    // Saturating counters, stepping on the same edge that raises res_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_r    <= '0;
            fault_count_r <= '0;
        end else begin
            if ((cap_clean_s | cap_retry_s) && (op_count_r != '1)) begin
                op_count_r <= op_count_r + STAT_ONE;
            end
            if (cap_retry_s && (fault_count_r != '1)) begin
                fault_count_r <= fault_count_r + STAT_ONE;
            end
        end
    end

    assign op_count    = op_count_r;
    assign fault_count = fault_count_r;
`else
    assign op_count    = '0;
    assign fault_count = '0;
`endif

endmodule
